// File: rtl/readout_pkg.sv
// Shared definitions for the pixel readout sequencer: FSM states,
// default timing constants and a small sizing helper.
package readout_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    EXPOSE,
    READ
  } state_e;

  localparam int DEF_NUM_ROWS    = 2;
  localparam int DEF_EXP_W       = 5;
  localparam int DEF_EXP_MIN     = 2;
  localparam int DEF_EXP_MAX     = 30;
  localparam int DEF_EXP_DEFAULT = 16;
  localparam int DEF_ERASE_CYC   = 2;
  localparam int DEF_ADC_CYC     = 9;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/exposure_register.sv
// Saturating up/down exposure-time register; only moves when enabled,
// and holds when both or neither direction is requested.
module exposure_register #(
  parameter int EXP_W       = 5,
  parameter int EXP_MIN     = 2,
  parameter int EXP_MAX     = 30,
  parameter int EXP_DEFAULT = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             enable_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [EXP_W-1:0] exp_o
);

  localparam logic [EXP_W-1:0] MIN_V = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] MAX_V = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] DEF_V = EXP_W'(EXP_DEFAULT);

  logic [EXP_W-1:0] exp_q;
  logic [EXP_W-1:0] exp_d;

  always_comb begin
    exp_d = exp_q;
    if (enable_i && inc_i && !dec_i && (exp_q < MAX_V)) begin
      exp_d = exp_q + 1'b1;
    end else if (enable_i && dec_i && !inc_i && (exp_q > MIN_V)) begin
      exp_d = exp_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      exp_q <= DEF_V;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_o = exp_q;

endmodule

// File: rtl/readout_sequencer.sv
// Frame sequencer for the pixel array: erase, expose, then read each row
// with a one-cold active-low enable and a centred ADC window.
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int NUM_ROWS    = DEF_NUM_ROWS,
  parameter int EXP_W       = DEF_EXP_W,
  parameter int EXP_MIN     = DEF_EXP_MIN,
  parameter int EXP_MAX     = DEF_EXP_MAX,
  parameter int EXP_DEFAULT = DEF_EXP_DEFAULT,
  parameter int ERASE_CYC   = DEF_ERASE_CYC,
  parameter int ADC_CYC     = DEF_ADC_CYC
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Exp_increase,
  input  logic                Exp_decrease,
  input  logic                Init,
  output logic                Erase,
  output logic                Expose,
  output logic [NUM_ROWS-1:0] NRE,
  output logic                ADC,
  output logic [EXP_W-1:0]    Exp_time,
  output logic                Busy,
  output logic                Frame_done
);

  localparam int PH_MAX = maxOf3(ERASE_CYC, EXP_MAX, ADC_CYC + 2);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [PH_W-1:0]  ERASE_LAST = PH_W'(ERASE_CYC - 1);
  localparam logic [PH_W-1:0]  ADC_LAST   = PH_W'(ADC_CYC);
  localparam logic [PH_W-1:0]  READ_LAST  = PH_W'(ADC_CYC + 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);

  state_e              state_q;
  logic [PH_W-1:0]     phase_q;
  logic [ROW_W-1:0]    row_q;
  logic                erase_q;
  logic                expose_q;
  logic [NUM_ROWS-1:0] nre_q;
  logic                adc_q;
  logic                busy_q;
  logic                frameDone_q;
  logic                expEnable;
  logic [PH_W-1:0]     expLast;

  function automatic logic [NUM_ROWS-1:0] oneCold(input logic [ROW_W-1:0] r);
    return ~(NUM_ROWS'(1) << r);
  endfunction

  // Init takes priority over the buttons, and the register is frozen for the
  // whole frame, so Exp_time doubles as the exposure latched at frame start.
  assign expEnable = (state_q == IDLE) && !Init;
  assign expLast   = PH_W'(Exp_time - 1'b1);

  exposure_register #(
    .EXP_W      (EXP_W),
    .EXP_MIN    (EXP_MIN),
    .EXP_MAX    (EXP_MAX),
    .EXP_DEFAULT(EXP_DEFAULT)
  ) u_exposure (
    .Clk     (Clk),
    .Reset   (Reset),
    .enable_i(expEnable),
    .inc_i   (Exp_increase),
    .dec_i   (Exp_decrease),
    .exp_o   (Exp_time)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      row_q       <= '0;
      erase_q     <= 1'b0;
      expose_q    <= 1'b0;
      nre_q       <= '1;
      adc_q       <= 1'b0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Init) begin
            state_q <= ERASE;
            erase_q <= 1'b1;
            busy_q  <= 1'b1;
            phase_q <= '0;
          end
        end
        ERASE: begin
          if (phase_q == ERASE_LAST) begin
            state_q  <= EXPOSE;
            erase_q  <= 1'b0;
            expose_q <= 1'b1;
            phase_q  <= '0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        EXPOSE: begin
          if (phase_q == expLast) begin
            state_q  <= READ;
            expose_q <= 1'b0;
            row_q    <= '0;
            nre_q    <= oneCold('0);
            phase_q  <= '0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        // Each row window is one setup cycle, ADC_CYC conversion cycles, one hold cycle.
        READ: begin
          if (phase_q == READ_LAST) begin
            phase_q <= '0;
            if (row_q == LAST_ROW) begin
              state_q     <= IDLE;
              row_q       <= '0;
              nre_q       <= '1;
              busy_q      <= 1'b0;
              frameDone_q <= 1'b1;
            end else begin
              row_q <= row_q + 1'b1;
              nre_q <= oneCold(row_q + 1'b1);
            end
          end else begin
            phase_q <= phase_q + 1'b1;
            adc_q   <= (phase_q < ADC_LAST);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Erase      = erase_q;
  assign Expose     = expose_q;
  assign NRE        = nre_q;
  assign ADC        = adc_q;
  assign Busy       = busy_q;
  assign Frame_done = frameDone_q;

endmodule
